// File: rtl/wt_wb_scheduler_pkg.sv
// Shared types for the weight SRAM write-back scheduler.
package snn_sched_pkg;

  typedef enum logic [1:0] {
    ARB,
    FLUSH,
    DONE
  } sched_state_t;

  localparam int WADDR_W      = 11;
  localparam int LANE_W       = 7;
  localparam int WLANE_DATA_W = 16;

  typedef struct packed {
    logic [WADDR_W-1:0]      addr;
    logic [LANE_W-1:0]       lane;
    logic [WLANE_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wt_wb_scheduler_fifo.sv
// Write-back FIFO of learned weight lanes with a parallel row-address match.
module wb_fifo
  import snn_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wb_entry_t                push_data,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [WADDR_W-1:0]       cmp_addr,
  output logic                     match_any
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset since occupancy gates every use.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PTR_W-1:0] offs;
    match_any = 1'b0;
    offs      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr;
      if (({1'b0, offs} < count) && (mem[i].addr == cmp_addr)) begin
        match_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wt_wb_scheduler.sv
// Weight SRAM arbiter: inference reads vs. buffered STDP lane write-backs.
module wt_wb_scheduler #(
  parameter int ADDR_W       = 11,
  parameter int LANE_W       = 7,
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_req,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_gnt,
  input  logic                     lrn_valid,
  output logic                     lrn_ready,
  input  logic [ADDR_W-1:0]        lrn_addr,
  input  logic [LANE_W-1:0]        lrn_lane,
  input  logic [DATA_W-1:0]        lrn_data,
  output logic [ADDR_W-1:0]        sram_addr,
  output logic                     sram_we,
  output logic [LANE_W-1:0]        sram_lane,
  output logic [DATA_W-1:0]        sram_wdata,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  import snn_sched_pkg::*;

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  sched_state_t    state;
  logic [SC_W-1:0] starve_cnt;
  wb_entry_t       push_entry;
  wb_entry_t       head;
  logic            full;
  logic            empty;
  logic            match_any;
  logic            hazard;
  logic            push;
  logic            write_sel;

  assign push_entry = '{addr: WADDR_W'(lrn_addr),
                        lane: snn_sched_pkg::LANE_W'(lrn_lane),
                        data: WLANE_DATA_W'(lrn_data)};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (write_sel),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count),
    .cmp_addr  (WADDR_W'(rd_addr)),
    .match_any (match_any)
  );

  assign hazard     = rd_req && match_any;
  assign lrn_ready  = !full && (state != FLUSH);
  assign push       = lrn_valid && lrn_ready;
  assign flush_done = (state == DONE);

  // Per-state grant decision between the read stream and the FIFO head.
  always_comb begin
    write_sel = 1'b0;
    rd_gnt    = 1'b0;
    case (state)
      ARB: begin
        write_sel = !empty && (full || (starve_cnt >= SC_W'(STARVE_LIMIT)) ||
                               hazard || !rd_req);
        rd_gnt    = rd_req && !write_sel;
      end
      FLUSH:   write_sel = !empty;
      default: ;
    endcase
  end

  // SRAM port mux; lane/data are zeroed on read cycles.
  always_comb begin
    sram_we    = write_sel;
    sram_addr  = write_sel ? ADDR_W'(head.addr) : rd_addr;
    sram_lane  = write_sel ? LANE_W'(head.lane) : '0;
    sram_wdata = write_sel ? DATA_W'(head.data) : '0;
  end

  // Flush sequencing and starvation counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      starve_cnt <= '0;
    end else begin
      case (state)
        ARB:     if (flush_req) state <= FLUSH;
        FLUSH:   if (empty) state <= DONE;
        default: state <= ARB;
      endcase
      if (write_sel || empty) begin
        starve_cnt <= '0;
      end else if (rd_gnt && (starve_cnt < SC_W'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wt_wb_scheduler.sv
// Directed bench for wt_wb_scheduler: reset, idle write-back, starvation,
// hazard, FIFO-full (second instance with a high starvation limit) and flush.
module tb_wt_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req;
  logic [10:0] rd_addr;
  logic        lrn_valid;
  logic [10:0] lrn_addr;
  logic [6:0]  lrn_lane;
  logic [15:0] lrn_data;
  logic        flush_req;

  logic        rd_gnt, lrn_ready, sram_we, flush_done;
  logic [10:0] sram_addr;
  logic [6:0]  sram_lane;
  logic [15:0] sram_wdata;
  logic [3:0]  fifo_count;

  logic        f_rd_gnt, f_lrn_ready, f_sram_we, f_flush_done;
  logic [10:0] f_sram_addr;
  logic [6:0]  f_sram_lane;
  logic [15:0] f_sram_wdata;
  logic [3:0]  f_fifo_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wt_wb_scheduler dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .lrn_valid(lrn_valid), .lrn_ready(lrn_ready), .lrn_addr(lrn_addr),
    .lrn_lane(lrn_lane), .lrn_data(lrn_data), .sram_addr(sram_addr),
    .sram_we(sram_we), .sram_lane(sram_lane), .sram_wdata(sram_wdata),
    .flush_req(flush_req), .flush_done(flush_done), .fifo_count(fifo_count)
  );

  wt_wb_scheduler #(.STARVE_LIMIT(15)) dut_full (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(f_rd_gnt),
    .lrn_valid(lrn_valid), .lrn_ready(f_lrn_ready), .lrn_addr(lrn_addr),
    .lrn_lane(lrn_lane), .lrn_data(lrn_data), .sram_addr(f_sram_addr),
    .sram_we(f_sram_we), .sram_lane(f_sram_lane), .sram_wdata(f_sram_wdata),
    .flush_req(flush_req), .flush_done(f_flush_done), .fifo_count(f_fifo_count)
  );

  // Inputs change at the negedge; outputs are checked 1 time unit later.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; rd_req = 1'b0; rd_addr = '0; flush_req = 1'b0;
    lrn_valid = 1'b1; lrn_addr = 11'h055; lrn_lane = 7'd3; lrn_data = 16'h1234;
    tick();
    tick();
    reset = 1'b0; lrn_valid = 1'b0;
    #1;
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (lrn_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", lrn_ready); end
    checks++; if (sram_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", sram_we); end
    checks++; if (rd_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got=%b exp=0", rd_gnt); end
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", flush_done); end
  endtask

  task automatic test_idle_writeback();
    rd_req = 1'b0;
    lrn_valid = 1'b1; lrn_addr = 11'h010; lrn_lane = 7'd5; lrn_data = 16'hBEEF;
    #1;
    checks++; if (sram_we !== 1'b0) begin errors++; $display("FAIL idle_c0_we got=%b exp=0", sram_we); end
    tick();
    lrn_valid = 1'b0;
    #1;
    checks++; if (sram_we !== 1'b1) begin errors++; $display("FAIL idle_c1_we got=%b exp=1", sram_we); end
    checks++; if (sram_addr !== 11'h010) begin errors++; $display("FAIL idle_c1_addr got=%h exp=010", sram_addr); end
    checks++; if (sram_lane !== 7'd5) begin errors++; $display("FAIL idle_c1_lane got=%0d exp=5", sram_lane); end
    checks++; if (sram_wdata !== 16'hBEEF) begin errors++; $display("FAIL idle_c1_wdata got=%h exp=beef", sram_wdata); end
    tick();
    #1;
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL idle_c2_count got=%0d exp=0", fifo_count); end
    checks++; if (sram_we !== 1'b0 || sram_wdata !== 16'h0 || sram_lane !== 7'd0) begin
      errors++; $display("FAIL idle_c2_mux we=%b lane=%0d wdata=%h exp we=0 lane=0 wdata=0", sram_we, sram_lane, sram_wdata);
    end
  endtask

  task automatic test_starvation();
    rd_req = 1'b1; rd_addr = 11'h100;
    lrn_valid = 1'b1; lrn_addr = 11'h020; lrn_lane = 7'd1; lrn_data = 16'h1111;
    #1;
    checks++; if (rd_gnt !== 1'b1 || sram_addr !== 11'h100) begin
      errors++; $display("FAIL starve_c0 gnt=%b addr=%h exp gnt=1 addr=100", rd_gnt, sram_addr);
    end
    tick();
    lrn_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++; if (rd_gnt !== 1'b1 || sram_we !== 1'b0) begin
        errors++; $display("FAIL starve_c%0d gnt=%b we=%b exp gnt=1 we=0", c, rd_gnt, sram_we);
      end
      tick();
    end
    #1;
    checks++; if (rd_gnt !== 1'b0 || sram_we !== 1'b1 || sram_addr !== 11'h020) begin
      errors++; $display("FAIL starve_c5 gnt=%b we=%b addr=%h exp gnt=0 we=1 addr=020", rd_gnt, sram_we, sram_addr);
    end
    tick();
    #1;
    checks++; if (rd_gnt !== 1'b1 || fifo_count !== 4'd0) begin
      errors++; $display("FAIL starve_c6 gnt=%b count=%0d exp gnt=1 count=0", rd_gnt, fifo_count);
    end
  endtask

  task automatic test_hazard();
    rd_req = 1'b1; rd_addr = 11'h123;
    lrn_valid = 1'b1; lrn_addr = 11'h123; lrn_lane = 7'd9; lrn_data = 16'hA5A5;
    #1;
    checks++; if (rd_gnt !== 1'b1 || sram_we !== 1'b0) begin
      errors++; $display("FAIL hazard_samecycle gnt=%b we=%b exp gnt=1 we=0", rd_gnt, sram_we);
    end
    tick();
    lrn_valid = 1'b0;
    #1;
    checks++; if (rd_gnt !== 1'b0 || sram_we !== 1'b1 || sram_addr !== 11'h123 || sram_wdata !== 16'hA5A5) begin
      errors++; $display("FAIL hazard_write gnt=%b we=%b addr=%h wdata=%h exp gnt=0 we=1 addr=123 wdata=a5a5",
                         rd_gnt, sram_we, sram_addr, sram_wdata);
    end
    tick();
    #1;
    checks++; if (rd_gnt !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 11'h123) begin
      errors++; $display("FAIL hazard_read gnt=%b we=%b addr=%h exp gnt=1 we=0 addr=123", rd_gnt, sram_we, sram_addr);
    end
  endtask

  task automatic test_flush();
    rd_req = 1'b1; rd_addr = 11'h100;
    for (int i = 0; i < 3; i++) begin
      lrn_valid = 1'b1; lrn_addr = 11'h300 + 11'(i); lrn_lane = 7'(i); lrn_data = 16'hC000 + 16'(i);
      tick();
    end
    lrn_valid = 1'b0; flush_req = 1'b1;
    #1;
    checks++; if (rd_gnt !== 1'b1 || sram_we !== 1'b0 || fifo_count !== 4'd3) begin
      errors++; $display("FAIL flush_c0 gnt=%b we=%b count=%0d exp gnt=1 we=0 count=3", rd_gnt, sram_we, fifo_count);
    end
    tick();
    flush_req = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++; if (rd_gnt !== 1'b0 || sram_we !== 1'b1 || lrn_ready !== 1'b0 ||
                    sram_addr !== 11'h300 + 11'(c - 1)) begin
        errors++; $display("FAIL flush_c%0d gnt=%b we=%b ready=%b addr=%h exp gnt=0 we=1 ready=0 addr=%h",
                           c, rd_gnt, sram_we, lrn_ready, sram_addr, 11'h300 + 11'(c - 1));
      end
      tick();
    end
    #1;
    checks++; if (fifo_count !== 4'd0 || flush_done !== 1'b0 || rd_gnt !== 1'b0 || sram_we !== 1'b0) begin
      errors++; $display("FAIL flush_c4 count=%0d done=%b gnt=%b we=%b exp 0 0 0 0", fifo_count, flush_done, rd_gnt, sram_we);
    end
    tick();
    #1;
    checks++; if (flush_done !== 1'b1 || rd_gnt !== 1'b0 || sram_we !== 1'b0) begin
      errors++; $display("FAIL flush_c5 done=%b gnt=%b we=%b exp done=1 gnt=0 we=0", flush_done, rd_gnt, sram_we);
    end
    tick();
    #1;
    checks++; if (flush_done !== 1'b0 || rd_gnt !== 1'b1) begin
      errors++; $display("FAIL flush_c6 done=%b gnt=%b exp done=0 gnt=1", flush_done, rd_gnt);
    end
  endtask

  task automatic test_full();
    reset = 1'b1; lrn_valid = 1'b0; rd_req = 1'b0; flush_req = 1'b0;
    tick();
    reset = 1'b0; rd_req = 1'b1; rd_addr = 11'h7FF;
    for (int i = 0; i < 8; i++) begin
      lrn_valid = 1'b1; lrn_addr = 11'h200 + 11'(i); lrn_lane = 7'(i); lrn_data = 16'(i);
      #1;
      checks++; if (f_lrn_ready !== 1'b1 || f_fifo_count !== 4'(i)) begin
        errors++; $display("FAIL full_push%0d ready=%b count=%0d exp ready=1 count=%0d", i, f_lrn_ready, f_fifo_count, i);
      end
      tick();
    end
    lrn_valid = 1'b0;
    #1;
    checks++; if (f_fifo_count !== 4'd8 || f_lrn_ready !== 1'b0) begin
      errors++; $display("FAIL full_at8 count=%0d ready=%b exp count=8 ready=0", f_fifo_count, f_lrn_ready);
    end
    checks++; if (f_sram_we !== 1'b1 || f_rd_gnt !== 1'b0 || f_sram_addr !== 11'h200) begin
      errors++; $display("FAIL full_forced we=%b gnt=%b addr=%h exp we=1 gnt=0 addr=200", f_sram_we, f_rd_gnt, f_sram_addr);
    end
    tick();
    #1;
    checks++; if (f_fifo_count !== 4'd7 || f_lrn_ready !== 1'b1 || f_rd_gnt !== 1'b1) begin
      errors++; $display("FAIL full_after count=%0d ready=%b gnt=%b exp count=7 ready=1 gnt=1", f_fifo_count, f_lrn_ready, f_rd_gnt);
    end
  endtask

  initial begin
    test_reset();
    test_idle_writeback();
    tick();
    test_starvation();
    tick();
    test_hazard();
    tick();
    test_flush();
    tick();
    test_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
